bus_scheduler: RTL and testbench
================================

Name: bus_scheduler

Overview:
- Shares one memory bus between the instruction and data request ports and routes each transaction to one of four slaves: rom, print, clint, bram.
- Sits between cpu and the peripheral/memory slaves.
- Adds per-port request capture, round-robin arbitration, address decode with base-address subtraction, a slave-response timeout and an error response.
- Exactly one transaction is outstanding at a time.

Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT before an error response is forced.
- NSLV, 4: slave count; index 0=rom, 1=print, 2=clint, 3=bram.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- imemory_valid  in  1  instruction request pulse
- imemory_instr  in  1  fetch flag
- imemory_addr  in  32  byte address
- imemory_wdata  in  32  write data
- imemory_wstrb  in  4  byte strobes; 0 means read
- imemory_rdata  out  32  response data
- imemory_ready  out  1  response pulse
- imemory_error  out  1  error flag, valid with ready
- dmemory_*  same set as imemory_*, for the data port
- slave_valid  out  NSLV  one-hot request pulse
- slave_instr  out  1  shared to all slaves
- slave_addr  out  32  address minus selected slave base
- slave_wdata  out  32  shared to all slaves
- slave_wstrb  out  4  shared to all slaves
- slave_rdata  in  NSLVx32  per-slave read data
- slave_ready  in  NSLV  per-slave response pulse

Behaviour:
- Clock and reset: single clock domain on clock. Reset is synchronous and active-high.
- Reset effects:
  - State goes to IDLE.
  - Both pending registers clear.
  - Priority pointer selects imemory.
  - Timeout counter clears.
  - All outputs are 0 at the first edge with reset high.
- Reset mid-transaction:
  - The transaction is abandoned with no requester ready.
  - A later slave_ready for it is ignored, because IDLE ignores slave_ready.
- Request capture:
  - A *_valid pulse (1 cycle) latches instr/addr/wdata/wstrb into that port's pending register.
  - A second pulse on a port whose pending bit is already set is dropped.
  - Capture works in every state, so a request arriving while the other port is being served is held, not lost.
- State IDLE:
  - If any pending bit is set, grant one port; arbitration and decode take the same cycle.
  - Both pending: grant the port named by the pointer, then point the pointer at the other port.
  - One pending: grant it; the pointer is unchanged.
  - Decode is priority-ordered: bram, clint, print, rom, using [base, top) from the configure package.
  - Mapped address: go to ISSUE.
  - Unmapped address: go to RESP with error=1 and rdata=0.
  - A request pulse arriving while IDLE is captured that cycle and granted the next cycle.
- State ISSUE (1 cycle):
  - Drive slave_valid[sel]=1 and the shared fields, with slave_addr = addr - base[sel].
  - Clear the timeout counter; go to WAIT.
- State WAIT:
  - slave_valid is 0.
  - On slave_ready[sel]: register slave_rdata[sel] and set error=0; go to RESP.
  - slave_ready on a non-selected index is ignored.
  - Otherwise increment the counter. At counter == TIMEOUT-1 with no ready: rdata=0, error=1; go to RESP.
  - Counter is 8 bits wide for the default; its width is $clog2(TIMEOUT+1).
- State RESP (1 cycle):
  - Pulse granted-port *_ready=1 with rdata and error.
  - Clear that port's pending bit; go to IDLE.
  - A new pulse on the same port in this cycle is dropped, since its pending bit is still set.
- Latency, request pulse at cycle 0 with the port idle:
  - Grant at cycle 1.
  - slave_valid at cycle 2.
  - Slave ready at cycle k gives requester ready at k+1; minimum is 4.
  - Unmapped address: ready at cycle 2.
- Simultaneous pulses on both ports at cycle 0: both are captured; the pointer decides which is served first; the second is granted in the IDLE cycle after the first's RESP.
- Outputs when not active: rdata and error hold 0 whenever ready=0. slave_addr/wdata are don't-care while no slave_valid is set.

Decomposition:
- configure package: bram/clint/print/rom base and top addresses (already exist); new typedef bus_req_t {instr, addr, wdata, wstrb}; state enum {IDLE, ISSUE, WAIT, RESP}; slave index localparams.
- One sub-module, bus_decode: combinational addr → {hit, sel[1:0], base}, so it can be verified standalone.

Test Plan:
- imem read at 0 (rom region), rom ready 2 cycles after slave_valid → slave_valid=0001, slave_addr=0; imemory_ready 3 cycles after slave_valid with rom data, error=0.
- imem and dmem pulses in the same cycle after reset, both bram → imem served first, dmem second; repeat the pair → dmem served first (pointer alternates).
- dmem write to bram_base_addr+8, wstrb=0011, wdata=0xDEADBEEF → slave_valid=1000, slave_addr=8, wstrb=0011, wdata passed through unchanged.
- Request to an unmapped address (above all tops) → no slave_valid; dmemory_ready 2 cycles after the pulse, error=1, rdata=0.
- bram never answers → dmemory_ready with error=1 exactly TIMEOUT cycles after entering WAIT; a late bram slave_ready is ignored, and the next request completes normally.
- reset asserted in WAIT → all outputs 0, no ready pulse issued; subsequent imem request served with latency 4.

Source files
------------

// File: rtl/bus_scheduler_pkg.sv
// Shared definitions for the bus scheduler: slave address map, slave
// indices, the captured request record and the scheduler state encoding.
package bus_scheduler_pkg;

  // Slave address windows, each [base, top).
  localparam logic [31:0] ROM_BASE_ADDR   = 32'h0000_0000;
  localparam logic [31:0] ROM_TOP_ADDR    = 32'h0001_0000;
  localparam logic [31:0] PRINT_BASE_ADDR = 32'h1000_0000;
  localparam logic [31:0] PRINT_TOP_ADDR  = 32'h1000_1000;
  localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP_ADDR  = 32'h0201_0000;
  localparam logic [31:0] BRAM_BASE_ADDR  = 32'h8000_0000;
  localparam logic [31:0] BRAM_TOP_ADDR   = 32'h8001_0000;

  localparam logic [1:0] SLV_ROM   = 2'd0;
  localparam logic [1:0] SLV_PRINT = 2'd1;
  localparam logic [1:0] SLV_CLINT = 2'd2;
  localparam logic [1:0] SLV_BRAM  = 2'd3;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_e;

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] top);
    return (addr >= base) && (addr < top);
  endfunction

endpackage

// File: rtl/bus_scheduler_if.sv
// Bus bundle between the cpu request ports, the scheduler and the slaves.
//   slave  modport : the scheduler's view (serves the cpu, drives slaves)
//   master modport : the environment's view (cpu ports + slave models)
interface bus_scheduler_if #(parameter int NSLV = 4) ();

  logic                 imemory_valid;
  logic                 imemory_instr;
  logic [31:0]          imemory_addr;
  logic [31:0]          imemory_wdata;
  logic [3:0]           imemory_wstrb;
  logic [31:0]          imemory_rdata;
  logic                 imemory_ready;
  logic                 imemory_error;

  logic                 dmemory_valid;
  logic                 dmemory_instr;
  logic [31:0]          dmemory_addr;
  logic [31:0]          dmemory_wdata;
  logic [3:0]           dmemory_wstrb;
  logic [31:0]          dmemory_rdata;
  logic                 dmemory_ready;
  logic                 dmemory_error;

  logic [NSLV-1:0]      slave_valid;
  logic                 slave_instr;
  logic [31:0]          slave_addr;
  logic [31:0]          slave_wdata;
  logic [3:0]           slave_wstrb;
  logic [NSLV-1:0][31:0] slave_rdata;
  logic [NSLV-1:0]      slave_ready;

  modport slave (
    input  imemory_valid, imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb,
    output imemory_rdata, imemory_ready, imemory_error,
    input  dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb,
    output dmemory_rdata, dmemory_ready, dmemory_error,
    output slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
    input  slave_rdata, slave_ready
  );

  modport master (
    output imemory_valid, imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb,
    input  imemory_rdata, imemory_ready, imemory_error,
    output dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb,
    input  dmemory_rdata, dmemory_ready, dmemory_error,
    input  slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
    output slave_rdata, slave_ready
  );

endinterface

// File: rtl/bus_scheduler_decode.sv
// Address decoder: maps a byte address to {hit, slave index, slave base}.
// Windows are checked in priority order bram, clint, print, rom.
//   addr_i : request byte address
//   hit_o  : address falls inside one of the slave windows
//   sel_o  : slave index (valid when hit_o)
//   base_o : base address of the selected slave (0 on miss)
module bus_decode
  import bus_scheduler_pkg::*;
(
  input  logic [31:0] addr_i,
  output logic        hit_o,
  output logic [1:0]  sel_o,
  output logic [31:0] base_o
);

  always_comb begin
    hit_o  = 1'b1;
    sel_o  = SLV_ROM;
    base_o = ROM_BASE_ADDR;
    if (in_range(addr_i, BRAM_BASE_ADDR, BRAM_TOP_ADDR)) begin
      sel_o  = SLV_BRAM;
      base_o = BRAM_BASE_ADDR;
    end else if (in_range(addr_i, CLINT_BASE_ADDR, CLINT_TOP_ADDR)) begin
      sel_o  = SLV_CLINT;
      base_o = CLINT_BASE_ADDR;
    end else if (in_range(addr_i, PRINT_BASE_ADDR, PRINT_TOP_ADDR)) begin
      sel_o  = SLV_PRINT;
      base_o = PRINT_BASE_ADDR;
    end else if (!in_range(addr_i, ROM_BASE_ADDR, ROM_TOP_ADDR)) begin
      hit_o  = 1'b0;
      base_o = '0;
    end
  end

endmodule

// File: rtl/bus_scheduler.sv
// Shares one slave bus between the instruction and data request ports.
// Captures requests per port, arbitrates round-robin, decodes to one of
// NSLV slaves, and returns a response (or an error on unmapped address or
// slave timeout). One transaction is outstanding at a time.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : cpu request/response ports and slave request/response
//
// state | meaning
// IDLE  | grant a pending port, decode its address
// ISSUE | slave_valid pulse to the selected slave
// WAIT  | wait for the selected slave_ready or timeout
// RESP  | ready pulse to the granted port, release its pending bit
module bus_scheduler
  import bus_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int NSLV    = 4
) (
  input  logic           clock,
  input  logic           reset,
  bus_scheduler_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  sched_state_e    state_q;
  logic [1:0]      pend_q, pend_d;
  bus_req_t        req_q [2];
  bus_req_t        req_d [2];
  logic            ptr_q;
  logic            gnt_q;
  logic [1:0]      sel_q;
  logic [CW-1:0]   cnt_q;

  logic [NSLV-1:0] sv_q;
  logic            s_instr_q;
  logic [31:0]     s_addr_q, s_wdata_q;
  logic [3:0]      s_wstrb_q;

  logic            i_ready_q, i_err_q, d_ready_q, d_err_q;
  logic [31:0]     i_rdata_q, d_rdata_q;

  logic            arb_gnt;
  bus_req_t        arb_req;
  logic            dec_hit;
  logic [1:0]      dec_sel;
  logic [31:0]     dec_base;

  // Capture runs in every state; a pulse on a port that is already pending
  // is dropped, including the RESP cycle that is about to release it.
  always_comb begin
    pend_d = pend_q;
    req_d  = req_q;
    if (state_q == RESP) pend_d[gnt_q] = 1'b0;
    if (bus.imemory_valid && !pend_q[0]) begin
      pend_d[0] = 1'b1;
      req_d[0]  = '{instr: bus.imemory_instr, addr: bus.imemory_addr,
                    wdata: bus.imemory_wdata, wstrb: bus.imemory_wstrb};
    end
    if (bus.dmemory_valid && !pend_q[1]) begin
      pend_d[1] = 1'b1;
      req_d[1]  = '{instr: bus.dmemory_instr, addr: bus.dmemory_addr,
                    wdata: bus.dmemory_wdata, wstrb: bus.dmemory_wstrb};
    end
  end

  // Pointer only matters on contention; a lone pending port wins outright.
  assign arb_gnt = (pend_q == 2'b11) ? ptr_q : pend_q[1];
  assign arb_req = req_q[arb_gnt];

  bus_decode u_decode (
    .addr_i (arb_req.addr),
    .hit_o  (dec_hit),
    .sel_o  (dec_sel),
    .base_o (dec_base)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      req_q[0]  <= '0;
      req_q[1]  <= '0;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      sel_q     <= '0;
      cnt_q     <= '0;
      sv_q      <= '0;
      s_instr_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      i_ready_q <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= req_d;
      case (state_q)
        IDLE: begin
          if (|pend_q) begin
            gnt_q <= arb_gnt;
            if (pend_q == 2'b11) ptr_q <= ~ptr_q;
            if (dec_hit) begin
              state_q   <= ISSUE;
              sel_q     <= dec_sel;
              sv_q      <= NSLV'(1) << dec_sel;
              s_instr_q <= arb_req.instr;
              s_addr_q  <= arb_req.addr - dec_base;
              s_wdata_q <= arb_req.wdata;
              s_wstrb_q <= arb_req.wstrb;
            end else begin
              state_q <= RESP;
              if (arb_gnt) begin
                d_ready_q <= 1'b1;
                d_err_q   <= 1'b1;
                d_rdata_q <= '0;
              end else begin
                i_ready_q <= 1'b1;
                i_err_q   <= 1'b1;
                i_rdata_q <= '0;
              end
            end
          end
        end
        ISSUE: begin
          sv_q    <= '0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.slave_ready[sel_q] || cnt_q == CNT_LAST) begin
            state_q <= RESP;
            // Timeout forces error with zero data.
            if (gnt_q) begin
              d_ready_q <= 1'b1;
              d_err_q   <= !bus.slave_ready[sel_q];
              d_rdata_q <= bus.slave_ready[sel_q] ? bus.slave_rdata[sel_q] : '0;
            end else begin
              i_ready_q <= 1'b1;
              i_err_q   <= !bus.slave_ready[sel_q];
              i_rdata_q <= bus.slave_ready[sel_q] ? bus.slave_rdata[sel_q] : '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          state_q   <= IDLE;
          i_ready_q <= 1'b0;
          i_err_q   <= 1'b0;
          i_rdata_q <= '0;
          d_ready_q <= 1'b0;
          d_err_q   <= 1'b0;
          d_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imemory_ready = i_ready_q;
  assign bus.imemory_error = i_err_q;
  assign bus.imemory_rdata = i_rdata_q;
  assign bus.dmemory_ready = d_ready_q;
  assign bus.dmemory_error = d_err_q;
  assign bus.dmemory_rdata = d_rdata_q;
  assign bus.slave_valid   = sv_q;
  assign bus.slave_instr   = s_instr_q;
  assign bus.slave_addr    = s_addr_q;
  assign bus.slave_wdata   = s_wdata_q;
  assign bus.slave_wstrb   = s_wstrb_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed self-checking bench for bus_scheduler.
module tb_bus_scheduler;
  import bus_scheduler_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  bus_scheduler_if #(.NSLV(4)) bus ();

  bus_scheduler #(.TIMEOUT(255), .NSLV(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? bus.dmemory_ready : bus.imemory_ready;
  endfunction
  function automatic logic [31:0] rd(input bit p);
    return p ? bus.dmemory_rdata : bus.imemory_rdata;
  endfunction
  function automatic logic er(input bit p);
    return p ? bus.dmemory_error : bus.imemory_error;
  endfunction

  task automatic drive_req(input bit p, input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    if (p) begin
      bus.dmemory_valid = 1'b1; bus.dmemory_instr = instr; bus.dmemory_addr = addr;
      bus.dmemory_wdata = wdata; bus.dmemory_wstrb = wstrb;
    end else begin
      bus.imemory_valid = 1'b1; bus.imemory_instr = instr; bus.imemory_addr = addr;
      bus.imemory_wdata = wdata; bus.imemory_wstrb = wstrb;
    end
  endtask

  task automatic clear_req();
    bus.imemory_valid = 1'b0;
    bus.dmemory_valid = 1'b0;
  endtask

  task automatic slave_answer(input logic [3:0] onehot, input logic [31:0] data);
    bus.slave_ready = onehot;
    for (int i = 0; i < 4; i++) bus.slave_rdata[i] = onehot[i] ? data : ~data;
  endtask

  // Mapped transaction: pulse at c0, slave_valid at c2, slave answers at
  // c3+delay, requester ready one cycle later.
  task automatic txn(input string tag, input bit p, input logic instr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic [3:0] exp_sv,
                     input logic [31:0] exp_saddr, input int delay,
                     input logic [31:0] data);
    drive_req(p, instr, addr, wdata, wstrb);
    tick(); clear_req();
    check({tag, ".c1_sv"}, bus.slave_valid, 4'b0000);
    tick();
    check({tag, ".sv"}, bus.slave_valid, exp_sv);
    check({tag, ".saddr"}, bus.slave_addr, exp_saddr);
    check({tag, ".swdata"}, bus.slave_wdata, wdata);
    check({tag, ".swstrb"}, bus.slave_wstrb, wstrb);
    check({tag, ".sinstr"}, bus.slave_instr, instr);
    tick();
    check({tag, ".wait_sv"}, bus.slave_valid, 4'b0000);
    for (int i = 0; i < delay; i++) begin
      check({tag, ".early_ready"}, rdy(p), 1'b0);
      tick();
    end
    slave_answer(exp_sv, data);
    tick();
    slave_answer(4'b0000, 32'h0);
    check({tag, ".ready"}, rdy(p), 1'b1);
    check({tag, ".rdata"}, rd(p), data);
    check({tag, ".error"}, er(p), 1'b0);
    check({tag, ".other_ready"}, rdy(!p), 1'b0);
    tick();
    check({tag, ".ready_drop"}, rdy(p), 1'b0);
    check({tag, ".rdata_zero"}, rd(p), 32'h0);
  endtask

  task automatic unmapped(input string tag, input bit p, input logic [31:0] addr);
    drive_req(p, 1'b0, addr, 32'h1234_5678, 4'b0000);
    tick(); clear_req();
    check({tag, ".c1_sv"}, bus.slave_valid, 4'b0000);
    check({tag, ".c1_ready"}, rdy(p), 1'b0);
    tick();
    check({tag, ".sv"}, bus.slave_valid, 4'b0000);
    check({tag, ".ready"}, rdy(p), 1'b1);
    check({tag, ".error"}, er(p), 1'b1);
    check({tag, ".rdata"}, rd(p), 32'h0);
    tick();
    check({tag, ".ready_drop"}, rdy(p), 1'b0);
    check({tag, ".error_drop"}, er(p), 1'b0);
  endtask

  // Both ports pulse together to bram; d_first says who the pointer favours.
  task automatic dual_round(input string tag, input bit d_first);
    logic [31:0] a [2];
    logic [31:0] dv [2];
    bit f;
    a[0] = BRAM_BASE_ADDR + 32'h10; a[1] = BRAM_BASE_ADDR + 32'h20;
    dv[0] = 32'hAAAA_0001;          dv[1] = 32'hBBBB_0002;
    drive_req(0, 1'b0, a[0], 32'h0, 4'b0000);
    drive_req(1, 1'b0, a[1], 32'h0, 4'b0000);
    tick(); clear_req();
    for (int k = 0; k < 2; k++) begin
      f = (k == 0) ? d_first : !d_first;
      check({tag, ".grant_sv"}, bus.slave_valid, 4'b0000);
      tick();
      check({tag, ".sv"}, bus.slave_valid, 4'b1000);
      check({tag, ".saddr"}, bus.slave_addr, a[f] - BRAM_BASE_ADDR);
      tick();
      slave_answer(4'b1000, dv[f]);
      tick();
      slave_answer(4'b0000, 32'h0);
      check({tag, ".ready"}, rdy(f), 1'b1);
      check({tag, ".rdata"}, rd(f), dv[f]);
      check({tag, ".other_ready"}, rdy(!f), 1'b0);
      tick();
      check({tag, ".ready_drop"}, rdy(f), 1'b0);
    end
  endtask

  int n;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.imemory_valid = 1'b0; bus.imemory_instr = 1'b0; bus.imemory_addr = '0;
    bus.imemory_wdata = '0;   bus.imemory_wstrb = '0;
    bus.dmemory_valid = 1'b0; bus.dmemory_instr = 1'b0; bus.dmemory_addr = '0;
    bus.dmemory_wdata = '0;   bus.dmemory_wstrb = '0;
    bus.slave_ready = '0;
    bus.slave_rdata = '0;

    tick();
    check("rst.sv", bus.slave_valid, 4'b0000);
    check("rst.iready", bus.imemory_ready, 1'b0);
    check("rst.dready", bus.dmemory_ready, 1'b0);
    check("rst.ierror", bus.imemory_error, 1'b0);
    check("rst.drdata", bus.dmemory_rdata, 32'h0);
    tick();
    reset = 1'b0;

    // imem fetch from rom, rom answers 2 cycles after slave_valid
    txn("rom_read", 0, 1'b1, 32'h0, 32'h0, 4'b0000, 4'b0001, 32'h0, 1, 32'h1122_3344);

    // pointer starts at imem, then alternates on contention
    dual_round("pair1", 1'b0);
    dual_round("pair2", 1'b1);

    // dmem partial write into bram
    txn("bram_wr", 1, 1'b0, BRAM_BASE_ADDR + 32'h8, 32'hDEAD_BEEF, 4'b0011,
        4'b1000, 32'h8, 0, 32'h0000_0005);

    // remaining slaves and the last rom word
    txn("clint", 1, 1'b0, CLINT_BASE_ADDR + 32'h4, 32'h0, 4'b0000, 4'b0100, 32'h4, 2, 32'hC1C1_0004);
    txn("print", 0, 1'b0, PRINT_BASE_ADDR + 32'h10, 32'h41, 4'b0001, 4'b0010, 32'h10, 0, 32'h0);
    txn("rom_last", 0, 1'b1, ROM_TOP_ADDR - 32'h4, 32'h0, 4'b0000, 4'b0001, 32'hFFFC, 0, 32'h0BAD_F00D);

    // unmapped addresses, including the first address past a window
    unmapped("unmap_high", 1, 32'hF000_0000);
    unmapped("unmap_romtop", 0, ROM_TOP_ADDR);
    unmapped("unmap_bramtop", 1, BRAM_TOP_ADDR);

    // bram never answers; a non-selected ready mid-wait must be ignored
    drive_req(1, 1'b0, BRAM_BASE_ADDR + 32'h40, 32'h0, 4'b0000);
    tick(); clear_req();
    tick();
    check("to.sv", bus.slave_valid, 4'b1000);
    n = 0;
    while (bus.dmemory_ready !== 1'b1 && n < 400) begin
      slave_answer((n == 8) ? 4'b0100 : 4'b0000, 32'h5555_5555);
      tick();
      n++;
    end
    slave_answer(4'b0000, 32'h0);
    check("to.latency", n, 256);
    check("to.error", bus.dmemory_error, 1'b1);
    check("to.rdata", bus.dmemory_rdata, 32'h0);
    tick();
    slave_answer(4'b1000, 32'h7777_7777);
    tick();
    slave_answer(4'b0000, 32'h0);
    check("to.late_dready", bus.dmemory_ready, 1'b0);
    tick();
    check("to.late_dready2", bus.dmemory_ready, 1'b0);
    check("to.late_iready", bus.imemory_ready, 1'b0);
    txn("after_to", 1, 1'b0, BRAM_BASE_ADDR + 32'h44, 32'h0, 4'b0000, 4'b1000, 32'h44, 0, 32'h9999_0001);

    // reset while waiting on rom
    drive_req(0, 1'b1, ROM_BASE_ADDR + 32'h100, 32'h0, 4'b0000);
    tick(); clear_req();
    tick();
    check("rstw.sv", bus.slave_valid, 4'b0001);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rstw.sv0", bus.slave_valid, 4'b0000);
    check("rstw.iready", bus.imemory_ready, 1'b0);
    check("rstw.dready", bus.dmemory_ready, 1'b0);
    check("rstw.saddr", bus.slave_addr, 32'h0);
    reset = 1'b0;
    slave_answer(4'b0001, 32'h7777_0000);
    tick();
    slave_answer(4'b0000, 32'h0);
    check("rstw.late_iready", bus.imemory_ready, 1'b0);
    tick();
    check("rstw.late_iready2", bus.imemory_ready, 1'b0);
    check("rstw.late_sv", bus.slave_valid, 4'b0000);
    txn("after_rst", 0, 1'b1, ROM_BASE_ADDR + 32'h100, 32'h0, 4'b0000, 4'b0001, 32'h100, 0, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
